// File: rtl/serial_bit_sequence_encoder.sv
// Serial 3-bit frame encoder: one-entry symbol buffer feeding a free-running
// PH0/PH1/PH2 frame shifter, with illegal (3'b111) symbol detection.
module serial_bit_sequence_encoder #(
    parameter logic [2:0] IDLE_SYM = 3'b000,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [2:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             out_bit,
    output logic             frame_start,
    output logic             illegal_sym,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_e;

    phase_e           phase_q, phase_d;
    logic [2:0]       shreg_q, shreg_d;
    logic [2:0]       buf_q, buf_d;
    logic             full_q, full_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             is_ill;

    assign sym_ready   = ~full_q;
    assign accept      = sym_valid & ~full_q;
    assign is_ill      = (sym_in == 3'b111);
    assign out_bit     = shreg_q[2];
    assign frame_start = (phase_q == PH0);
    assign illegal_sym = ill_q;
    assign illegal_cnt = cnt_q;

    always_comb begin
        phase_d = PH0;
        shreg_d = shreg_q;
        buf_d   = buf_q;
        full_d  = full_q;
        ill_d   = 1'b0;
        cnt_d   = cnt_q;

        case (phase_q)
            PH0: begin
                phase_d = PH1;
                shreg_d = {shreg_q[1:0], 1'b0};
            end
            PH1: begin
                phase_d = PH2;
                shreg_d = {shreg_q[1:0], 1'b0};
            end
            default: begin
                // PH2 and any stray encoding: start a fresh frame.
                phase_d = PH0;
                shreg_d = full_q ? buf_q : IDLE_SYM;
                full_d  = 1'b0;
            end
        endcase

        // accept implies the buffer was empty, so this never
        // collides with the frame-load drain above.
        if (accept) begin
            buf_d  = is_ill ? 3'b110 : sym_in;
            full_d = 1'b1;
            ill_d  = is_ill;
        end

        if (ill_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q <= PH0;
            shreg_q <= IDLE_SYM;
            buf_q   <= 3'b000;
            full_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_sequence_encoder.sv
// Bench for serial_bit_sequence_encoder: vector table, directed corner
// sequences and randomized traffic against a frame-level reference model.
module tb_serial_bit_sequence_encoder;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       sym_valid = 1'b0;
    logic [2:0] sym_in = 3'b000;

    logic       rdy, ob, fs, ill;
    logic [7:0] cnt;
    logic       rdy2, ob2, fs2, ill2;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    serial_bit_sequence_encoder u_dut (
        .clk(clk), .n_reset(n_reset), .sym_in(sym_in),
        .sym_valid(sym_valid), .sym_ready(rdy), .out_bit(ob),
        .frame_start(fs), .illegal_sym(ill), .illegal_cnt(cnt)
    );

    serial_bit_sequence_encoder #(.CNT_W(2)) u_dut2 (
        .clk(clk), .n_reset(n_reset), .sym_in(sym_in),
        .sym_valid(sym_valid), .sym_ready(rdy2), .out_bit(ob2),
        .frame_start(fs2), .illegal_sym(ill2), .illegal_cnt(cnt2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: current frame indexed by phase, one pending slot.
    int         ph;
    logic [2:0] mf;
    bit         mpv;
    logic [2:0] mpend;
    bit         mill;
    int         mtot;
    bit         macc;

    logic [2:0] frames[$];
    logic [2:0] fr;
    int         fcnt;

    logic s_ob, s_fs, s_rdy, s_ill;

    typedef struct {
        bit         v;
        logic [2:0] s;
        bit         eo;
        bit         efs;
        bit         erdy;
        bit         eill;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        ph   = 0;
        mf   = 3'b000;
        mpv  = 1'b0;
        mill = 1'b0;
        mtot = 0;
        fcnt = 0;
    endtask

    task automatic m_edge(input bit v, input logic [2:0] s);
        macc = v && !mpv;
        if (ph == 2) begin
            mf  = mpv ? mpend : 3'b000;
            mpv = 1'b0;
        end
        if (macc) begin
            mpend = (s == 3'b111) ? 3'b110 : s;
            mpv   = 1'b1;
        end
        mill = macc && (s == 3'b111);
        if (mill) mtot++;
        ph = (ph + 1) % 3;
    endtask

    task automatic m_check();
        chk("out_bit", ob, mf[2-ph]);
        chk("out_bit_w2", ob2, mf[2-ph]);
        chk("frame_start", fs, (ph == 0));
        chk("sym_ready", rdy, !mpv);
        chk("sym_ready_w2", rdy2, !mpv);
        chk("illegal_sym", ill, mill);
        chk("illegal_sym_w2", ill2, mill);
        chk("illegal_cnt", cnt, (mtot > 255) ? 255 : mtot);
        chk("illegal_cnt_w2", cnt2, (mtot > 3) ? 3 : mtot);
    endtask

    task automatic cyc(input bit v, input logic [2:0] s);
        sym_valid = v;
        sym_in    = s;
        @(negedge clk);
        m_check();
        s_ob  = ob;
        s_fs  = fs;
        s_rdy = rdy;
        s_ill = ill;
        if (fs) fcnt = 0;
        fr = {fr[1:0], ob};
        fcnt++;
        if (fcnt == 3) begin
            frames.push_back(fr);
            fcnt = 0;
        end
        @(posedge clk);
        m_edge(v, s);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        m_reset();
        #1;
        chk("rst_frame_start", fs, 1);
        chk("rst_out_bit", ob, 0);
        chk("rst_sym_ready", rdy, 1);
        chk("rst_illegal_sym", ill, 0);
        chk("rst_illegal_cnt", cnt, 0);
        chk("rst_illegal_cnt_w2", cnt2, 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    task automatic send(input logic [2:0] s);
        int n = 0;
        do begin
            cyc(1'b1, s);
            n++;
        end while (!macc && n < 10);
        chk("send_accepted", macc, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'($urandom_range(0, 7)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, n6, n7, nz;

        tbl[0]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};

        fr = 3'b000;
        do_reset();

        for (int k = 0; k < 18; k++) begin
            cyc(tbl[k].v, tbl[k].s);
            chk($sformatf("tbl%0d_out", k), s_ob, tbl[k].eo);
            chk($sformatf("tbl%0d_fs", k), s_fs, tbl[k].efs);
            chk($sformatf("tbl%0d_rdy", k), s_rdy, tbl[k].erdy);
            chk($sformatf("tbl%0d_ill", k), s_ill, tbl[k].eill);
        end
        chk("tbl_cnt", cnt, 1);

        // Reset in PH1 of a 3'b110 frame with 3'b011 buffered.
        cyc(1'b1, 3'b110);
        cyc(1'b0, 3'b000);
        cyc(1'b0, 3'b000);
        cyc(1'b1, 3'b011);
        do_reset();
        frames.delete();
        idle(12);
        nz = 0;
        foreach (frames[j]) if (frames[j] == 3'b000) nz++;
        chk("midrst_frames", frames.size(), 4);
        chk("midrst_idle_frames", nz, 4);
        chk("midrst_cnt", cnt, 0);

        frames.delete();
        idle(30);
        nz = 0;
        foreach (frames[j]) if (frames[j] == 3'b000) nz++;
        chk("idle_frames", frames.size(), 10);
        chk("idle_zero_frames", nz, 10);

        frames.delete();
        send(3'b110);
        send(3'b011);
        send(3'b100);
        idle(9);
        i0 = -1;
        foreach (frames[j]) if (i0 < 0 && frames[j] != 3'b000) i0 = j;
        if (i0 < 0 || i0 + 2 >= frames.size()) begin
            chk("b2b_found", 0, 1);
        end else begin
            chk("b2b_f0", frames[i0], 3'b110);
            chk("b2b_f1", frames[i0+1], 3'b011);
            chk("b2b_f2", frames[i0+2], 3'b100);
        end

        frames.delete();
        for (int k = 0; k < 5; k++) send(3'b111);
        idle(6);
        n6 = 0;
        n7 = 0;
        foreach (frames[j]) begin
            if (frames[j] == 3'b110) n6++;
            if (frames[j] == 3'b111) n7++;
        end
        chk("ill_sat_w2", cnt2, 3);
        chk("ill_cnt_w8", cnt, 5);
        chk("ill_frames_110", n6, 5);
        chk("ill_frames_111", n7, 0);

        frames.delete();
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)));
            end
        end
        n7 = 0;
        foreach (frames[j]) if (frames[j] == 3'b111) n7++;
        chk("rand_no_111", n7, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
